replay_scheduler: RTL and testbench

Retry controller for the data-link replay path. It assigns sequence numbers to outgoing packets and tracks the outstanding window between the last acknowledged and next-to-send sequence number. It turns ACK/NAK DLLPs and replay-timer expiry into purge and replay commands for the replay buffer's FIFO (`num_packets_to_replay`, `rd`, `rep` side), and sits between the DLLP receive logic and the replay buffer.

---
 rtl/replay_pkg.sv | 35 +++
 rtl/replay_scheduler_if.sv | 40 ++++
 rtl/replay_timer.sv | 38 +++
 rtl/replay_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_replay_scheduler.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/replay_pkg.sv
// -----------------------------------------------------------------------------
// replay_pkg
// Shared definitions for the data-link replay scheduler: DLLP type codes,
// scheduler state encoding, default sequence width and the modulo sequence
// difference helper.
// No ports (package).
// -----------------------------------------------------------------------------
package replay_pkg;

   localparam int SEQ_W_DEF = 12;

   localparam logic [1:0] DLLP_ACK = 2'b01;
   localparam logic [1:0] DLLP_NAK = 2'b10;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT       = 2'd1,
      REPLAY_REQ = 2'd2,
      REPLAY     = 2'd3
   } state_e;

   // (a - b) mod 2^w, carried in a 32-bit container; callers narrow to SEQ_W.
   function automatic logic [31:0] seq_diff(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          w);
      logic [31:0] mask_v;
      if (w >= 32) begin
         mask_v = 32'hFFFF_FFFF;
      end else begin
         mask_v = (32'd1 << w) - 32'd1;
      end
      return (a - b) & mask_v;
   endfunction

endpackage

// File: rtl/replay_scheduler_if.sv
// -----------------------------------------------------------------------------
// replay_scheduler_if
// Bundles the transmit handshake, DLLP receive inputs and replay-buffer
// command/status signals of the replay scheduler.
// Modports:
//   master : the scheduler (drives tx_ready, next_seq, purge_*, rep_start,
//            rep_count, rep_busy, ackd_seq, seq_err, retrain_req)
//   slave  : link/buffer side (drives tx_valid, dllp_*, rep_done)
// -----------------------------------------------------------------------------
interface replay_scheduler_if #(
   parameter int SEQ_W = replay_pkg::SEQ_W_DEF
);
   logic             tx_valid;
   logic             tx_ready;
   logic [SEQ_W-1:0] next_seq;
   logic             dllp_valid;
   logic [1:0]       dllp_type;
   logic [SEQ_W-1:0] dllp_seq;
   logic             purge_valid;
   logic [SEQ_W-1:0] purge_count;
   logic             rep_start;
   logic [SEQ_W-1:0] rep_count;
   logic             rep_busy;
   logic             rep_done;
   logic [SEQ_W-1:0] ackd_seq;
   logic             seq_err;
   logic             retrain_req;

   modport master (
      input  tx_valid, dllp_valid, dllp_type, dllp_seq, rep_done,
      output tx_ready, next_seq, purge_valid, purge_count, rep_start,
             rep_count, rep_busy, ackd_seq, seq_err, retrain_req
   );

   modport slave (
      output tx_valid, dllp_valid, dllp_type, dllp_seq, rep_done,
      input  tx_ready, next_seq, purge_valid, purge_count, rep_start,
             rep_count, rep_busy, ackd_seq, seq_err, retrain_req
   );
endinterface

// File: rtl/replay_timer.sv
// -----------------------------------------------------------------------------
// replay_timer
// Replay timer: counts clock cycles while enabled, returns to zero on clear.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : force the count to zero (wins over enable)
//   enable   : count this cycle
//   expired  : count has reached TIMEOUT-1 while enabled
// -----------------------------------------------------------------------------
module replay_timer #(
   parameter int TIMEOUT = 1000,
   parameter int TIMER_W = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   logic [TIMER_W-1:0] count_r;

   // Cycle counter with clear priority over enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {TIMER_W{1'b0}};
      end else if (clear) begin
         count_r <= {TIMER_W{1'b0}};
      end else if (enable) begin
         count_r <= count_r + {{(TIMER_W-1){1'b0}}, 1'b1};
      end
   end

   // Expiry is flagged on the last counted cycle so the replay request is
   // registered exactly TIMEOUT cycles after the timer was last zeroed.
   assign expired = enable & (count_r == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/replay_scheduler.sv
// -----------------------------------------------------------------------------
// replay_scheduler
// Data-link replay controller: numbers outgoing packets, tracks the window
// between the last acknowledged and next-to-send sequence numbers, and turns
// ACK/NAK DLLPs and replay-timer expiry into purge and replay commands.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : replay_scheduler_if.master (tx handshake, DLLP input,
//              purge/replay commands, status pulses)
// Optional feature: define REPLAY_SCHED_RETRAIN_EN to count consecutive
// replays in a 2-bit counter and pulse retrain_req on its rollover.
// -----------------------------------------------------------------------------
module replay_scheduler
   import replay_pkg::*;
#(
   parameter int SEQ_W   = SEQ_W_DEF,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 1000,
   parameter int TIMER_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   replay_scheduler_if.master bus
);

   localparam logic [1:0] S_IDLE       = IDLE;
   localparam logic [1:0] S_WAIT       = WAIT;
   localparam logic [1:0] S_REPLAY_REQ = REPLAY_REQ;
   localparam logic [1:0] S_REPLAY     = REPLAY;

   localparam logic [SEQ_W-1:0] SEQ_ZERO = {SEQ_W{1'b0}};
   localparam logic [SEQ_W-1:0] SEQ_ONE  = {{(SEQ_W-1){1'b0}}, 1'b1};

   logic [SEQ_W-1:0] next_seq_r, ackd_seq_r, purge_count_r, rep_count_r;
   logic [1:0]       state_r;
   logic             tx_ready_r, purge_valid_r, rep_start_r, rep_busy_r;
   logic             seq_err_r, nak_pend_r;

   logic             tx_acc_s, dllp_ok_s, in_win_s, progress_s, nak_s;
   logic             expired_s, timer_clr_s, timer_en_s, enter_req_s;
   logic [SEQ_W-1:0] out_s, d_s, rem_out_s, next_seq_nxt_s, ackd_nxt_s, out_nxt_s;
   logic [1:0]       state_nxt_s;
   logic             nak_pend_nxt_s;

   // Window arithmetic; all DLLP checks use the pre-update values.
   assign tx_acc_s       = bus.tx_valid & tx_ready_r;
   assign out_s          = next_seq_r - ackd_seq_r - SEQ_ONE;
   assign d_s            = SEQ_W'(seq_diff(32'(bus.dllp_seq), 32'(ackd_seq_r), SEQ_W));
   assign dllp_ok_s      = bus.dllp_valid &
                           ((bus.dllp_type == DLLP_ACK) | (bus.dllp_type == DLLP_NAK));
   assign in_win_s       = (d_s <= out_s);
   assign progress_s     = dllp_ok_s & in_win_s & (d_s != SEQ_ZERO);
   assign nak_s          = dllp_ok_s & in_win_s & (bus.dllp_type == DLLP_NAK);
   // Packets still outstanding once this cycle's purge is applied, not
   // counting a packet accepted in the same cycle.
   assign rem_out_s      = progress_s ? (out_s - d_s) : out_s;
   assign next_seq_nxt_s = next_seq_r + (tx_acc_s ? SEQ_ONE : SEQ_ZERO);
   assign ackd_nxt_s     = progress_s ? bus.dllp_seq : ackd_seq_r;
   assign out_nxt_s      = next_seq_nxt_s - ackd_nxt_s - SEQ_ONE;

   // Next-state and pending-NAK logic.
   always_comb begin
      state_nxt_s    = state_r;
      nak_pend_nxt_s = nak_pend_r;
      case (state_r)
         S_IDLE: begin
            if (tx_acc_s) begin
               state_nxt_s = S_WAIT;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WAIT: begin
            // A NAK outranks everything; forward progress suppresses a
            // coincident timeout.
            if (nak_s && (rem_out_s != SEQ_ZERO)) begin
               state_nxt_s = S_REPLAY_REQ;
            end else if (out_nxt_s == SEQ_ZERO) begin
               state_nxt_s = S_IDLE;
            end else if (expired_s && !progress_s) begin
               state_nxt_s = S_REPLAY_REQ;
            end else begin
               state_nxt_s = S_WAIT;
            end
         end
         S_REPLAY_REQ: begin
            state_nxt_s    = S_REPLAY;
            nak_pend_nxt_s = nak_pend_r | nak_s;
         end
         S_REPLAY: begin
            if (bus.rep_done) begin
               nak_pend_nxt_s = 1'b0;
               if ((nak_pend_r || nak_s) && (out_nxt_s != SEQ_ZERO)) begin
                  state_nxt_s = S_REPLAY_REQ;
               end else if (out_nxt_s != SEQ_ZERO) begin
                  state_nxt_s = S_WAIT;
               end else begin
                  state_nxt_s = S_IDLE;
               end
            end else begin
               state_nxt_s    = S_REPLAY;
               nak_pend_nxt_s = nak_pend_r | nak_s;
            end
         end
         default: begin
            state_nxt_s    = S_IDLE;
            nak_pend_nxt_s = 1'b0;
         end
      endcase
   end

   assign enter_req_s = (state_nxt_s == S_REPLAY_REQ);
   // Timer restarts on forward progress and on every entry to WAIT; it is
   // held at zero in every other state.
   assign timer_clr_s = progress_s | (state_r != S_WAIT) | (state_nxt_s != S_WAIT);
   assign timer_en_s  = (state_r == S_WAIT);

   replay_timer #(
      .TIMEOUT (TIMEOUT),
      .TIMER_W (TIMER_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clr_s),
      .enable  (timer_en_s),
      .expired (expired_s)
   );

   // Scheduler state and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         next_seq_r    <= SEQ_ZERO;
         ackd_seq_r    <= {SEQ_W{1'b1}};
         state_r       <= S_IDLE;
         nak_pend_r    <= 1'b0;
         tx_ready_r    <= 1'b1;
         purge_valid_r <= 1'b0;
         purge_count_r <= SEQ_ZERO;
         seq_err_r     <= 1'b0;
         rep_start_r   <= 1'b0;
         rep_busy_r    <= 1'b0;
         rep_count_r   <= SEQ_ZERO;
      end else begin
         next_seq_r    <= next_seq_nxt_s;
         ackd_seq_r    <= ackd_nxt_s;
         state_r       <= state_nxt_s;
         nak_pend_r    <= nak_pend_nxt_s;
         tx_ready_r    <= (out_nxt_s < SEQ_W'(DEPTH)) &&
                          (state_nxt_s != S_REPLAY_REQ) && (state_nxt_s != S_REPLAY);
         purge_valid_r <= progress_s;
         purge_count_r <= progress_s ? d_s : SEQ_ZERO;
         seq_err_r     <= dllp_ok_s & ~in_win_s;
         rep_start_r   <= enter_req_s;
         rep_busy_r    <= (state_nxt_s == S_REPLAY_REQ) || (state_nxt_s == S_REPLAY);
         if (enter_req_s) begin
            rep_count_r <= rem_out_s;
         end
      end
   end

`ifdef REPLAY_SCHED_RETRAIN_EN
   logic [1:0] replay_num_r;
   logic       retrain_req_r;

   // Consecutive-replay counter; forward progress restarts the count.
   always_ff @(posedge clk) begin
      if (rst) begin
         replay_num_r  <= 2'd0;
         retrain_req_r <= 1'b0;
      end else if (enter_req_s) begin
         replay_num_r  <= (progress_s ? 2'd0 : replay_num_r) + 2'd1;
         retrain_req_r <= ~progress_s & (replay_num_r == 2'd3);
      end else begin
         replay_num_r  <= progress_s ? 2'd0 : replay_num_r;
         retrain_req_r <= 1'b0;
      end
   end

   assign bus.retrain_req = retrain_req_r;
`else
   assign bus.retrain_req = 1'b0;
`endif

   assign bus.tx_ready    = tx_ready_r;
   assign bus.next_seq    = next_seq_r;
   assign bus.ackd_seq    = ackd_seq_r;
   assign bus.purge_valid = purge_valid_r;
   assign bus.purge_count = purge_count_r;
   assign bus.seq_err     = seq_err_r;
   assign bus.rep_start   = rep_start_r;
   assign bus.rep_busy    = rep_busy_r;
   assign bus.rep_count   = rep_count_r;

endmodule

// File: tb/tb_replay_scheduler.sv
// -----------------------------------------------------------------------------
// tb_replay_scheduler
// Directed self-checking bench for replay_scheduler (SEQ_W=12, DEPTH=16,
// TIMEOUT shortened to 20 cycles). Inputs change 1 ns after the rising edge;
// outputs are read at that same point, i.e. after the edge has settled.
// -----------------------------------------------------------------------------
module tb_replay_scheduler;

   localparam int SW = 12;
   localparam int DP = 16;
   localparam int TO = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   replay_scheduler_if #(.SEQ_W(SW)) bus ();

   replay_scheduler #(.SEQ_W(SW), .DEPTH(DP), .TIMEOUT(TO), .TIMER_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.tx_valid = 1'b0; bus.dllp_valid = 1'b0; bus.dllp_type = 2'b00;
      bus.dllp_seq = 12'd0; bus.rep_done = 1'b0;
      rst = 1'b1; step(); step(); rst = 1'b0;
   endtask

   task automatic send(input int n);
      bus.tx_valid = 1'b1;
      repeat (n) step();
      bus.tx_valid = 1'b0;
   endtask

   task automatic dllp(input logic [1:0] t, input logic [11:0] s);
      bus.dllp_valid = 1'b1; bus.dllp_type = t; bus.dllp_seq = s;
      step();
      bus.dllp_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.next_seq !== 12'd0) begin failures++; $display("FAIL reset_next_seq got=%0d exp=0", bus.next_seq); end
      checks++; if (bus.ackd_seq !== 12'hFFF) begin failures++; $display("FAIL reset_ackd_seq got=%0h exp=fff", bus.ackd_seq); end
      checks++; if (bus.tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready got=%0b exp=1", bus.tx_ready); end
      checks++; if ({bus.purge_valid, bus.rep_start, bus.rep_busy, bus.seq_err, bus.retrain_req} !== 5'b0)
         begin failures++; $display("FAIL reset_pulses got=%05b exp=00000", {bus.purge_valid, bus.rep_start, bus.rep_busy, bus.seq_err, bus.retrain_req}); end
      checks++; if (bus.rep_count !== 12'd0 || bus.purge_count !== 12'd0)
         begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bus.rep_count, bus.purge_count); end
   endtask

   task automatic test_ack();
      int starts;
      do_reset();
      send(3);
      checks++; if (bus.next_seq !== 12'd3) begin failures++; $display("FAIL ack_next_seq got=%0d exp=3", bus.next_seq); end
      dllp(2'b01, 12'd2);
      checks++; if (bus.purge_valid !== 1'b1 || bus.purge_count !== 12'd3)
         begin failures++; $display("FAIL ack_purge got=%0b/%0d exp=1/3", bus.purge_valid, bus.purge_count); end
      checks++; if (bus.ackd_seq !== 12'd2) begin failures++; $display("FAIL ack_ackd_seq got=%0d exp=2", bus.ackd_seq); end
      step();
      checks++; if (bus.purge_valid !== 1'b0 || bus.purge_count !== 12'd0)
         begin failures++; $display("FAIL ack_purge_pulse got=%0b/%0d exp=0/0", bus.purge_valid, bus.purge_count); end
      // Idle: timer stopped, so no replay may ever be issued.
      starts = 0;
      for (int k = 0; k < TO + 5; k++) begin step(); if (bus.rep_start === 1'b1) starts++; end
      checks++; if (starts !== 0 || bus.tx_ready !== 1'b1)
         begin failures++; $display("FAIL ack_idle got=%0d starts ready=%0b exp=0 starts ready=1", starts, bus.tx_ready); end
   endtask

   task automatic test_nak();
      int k_hit;
      do_reset();
      send(5);
      dllp(2'b10, 12'd1);
      checks++; if (bus.purge_valid !== 1'b1 || bus.purge_count !== 12'd2)
         begin failures++; $display("FAIL nak_purge got=%0b/%0d exp=1/2", bus.purge_valid, bus.purge_count); end
      checks++; if (bus.rep_start !== 1'b1 || bus.rep_count !== 12'd3 || bus.rep_busy !== 1'b1)
         begin failures++; $display("FAIL nak_rep_start got=%0b/%0d/%0b exp=1/3/1", bus.rep_start, bus.rep_count, bus.rep_busy); end
      checks++; if (bus.tx_ready !== 1'b0) begin failures++; $display("FAIL nak_tx_ready got=%0b exp=0", bus.tx_ready); end
      step();
      checks++; if (bus.rep_start !== 1'b0 || bus.rep_busy !== 1'b1 || bus.rep_count !== 12'd3)
         begin failures++; $display("FAIL nak_replay got=%0b/%0b/%0d exp=0/1/3", bus.rep_start, bus.rep_busy, bus.rep_count); end
      bus.rep_done = 1'b1; step(); bus.rep_done = 1'b0;
      checks++; if (bus.rep_busy !== 1'b0 || bus.tx_ready !== 1'b1)
         begin failures++; $display("FAIL nak_done got=%0b/%0b exp=0/1", bus.rep_busy, bus.tx_ready); end
      // Back in WAIT with a fresh timer: replay after exactly TO cycles.
      k_hit = 0;
      for (int k = 1; k <= TO + 5; k++) begin step(); if (bus.rep_start === 1'b1 && k_hit == 0) k_hit = k; end
      checks++; if (k_hit !== TO) begin failures++; $display("FAIL nak_wait_timeout got=%0d exp=%0d", k_hit, TO); end
   endtask

   task automatic test_timeout();
      int k_hit;
      logic rt;
      do_reset();
      send(1);
      for (int n = 1; n <= 4; n++) begin
         k_hit = 0; rt = 1'b0;
         for (int k = 1; k <= TO + 5; k++) begin
            step();
            if (bus.rep_start === 1'b1 && k_hit == 0) begin k_hit = k; rt = bus.retrain_req; end
            if (k_hit != 0) break;
         end
         checks++; if (k_hit !== TO) begin failures++; $display("FAIL timeout_%0d_cycles got=%0d exp=%0d", n, k_hit, TO); end
         checks++; if (bus.rep_count !== 12'd1) begin failures++; $display("FAIL timeout_%0d_rep_count got=%0d exp=1", n, bus.rep_count); end
`ifdef REPLAY_SCHED_RETRAIN_EN
         checks++; if (rt !== (n == 4)) begin failures++; $display("FAIL timeout_%0d_retrain got=%0b exp=%0b", n, rt, (n == 4)); end
`else
         checks++; if (rt !== 1'b0) begin failures++; $display("FAIL timeout_%0d_retrain got=%0b exp=0", n, rt); end
`endif
         step();
         bus.rep_done = 1'b1; step(); bus.rep_done = 1'b0;
      end
   endtask

   task automatic test_wrap();
      int ns, n;
      do_reset();
      ns = 0;
      while (ns < 4094) begin
         n = (4094 - ns < 14) ? (4094 - ns) : 14;
         send(n);
         ns += n;
         dllp(2'b01, 12'(ns - 1));
      end
      checks++; if (bus.next_seq !== 12'd4094 || bus.ackd_seq !== 12'd4093)
         begin failures++; $display("FAIL wrap_preload got=%0d/%0d exp=4094/4093", bus.next_seq, bus.ackd_seq); end
      send(15);
      checks++; if (bus.next_seq !== 12'd13 || bus.tx_ready !== 1'b1)
         begin failures++; $display("FAIL wrap_15 got=%0d/%0b exp=13/1", bus.next_seq, bus.tx_ready); end
      send(1);
      checks++; if (bus.tx_ready !== 1'b0) begin failures++; $display("FAIL wrap_full_ready got=%0b exp=0", bus.tx_ready); end
      send(1);
      checks++; if (bus.next_seq !== 12'd14) begin failures++; $display("FAIL wrap_full_block got=%0d exp=14", bus.next_seq); end
      dllp(2'b01, 12'd3);
      checks++; if (bus.purge_valid !== 1'b1 || bus.purge_count !== 12'd6)
         begin failures++; $display("FAIL wrap_purge got=%0b/%0d exp=1/6", bus.purge_valid, bus.purge_count); end
      checks++; if (bus.ackd_seq !== 12'd3 || bus.tx_ready !== 1'b1)
         begin failures++; $display("FAIL wrap_after_ack got=%0d/%0b exp=3/1", bus.ackd_seq, bus.tx_ready); end
   endtask

   task automatic test_seq_err();
      do_reset();
      send(5);
      dllp(2'b01, 12'd0);
      checks++; if (bus.ackd_seq !== 12'd0 || bus.purge_count !== 12'd1)
         begin failures++; $display("FAIL err_setup got=%0d/%0d exp=0/1", bus.ackd_seq, bus.purge_count); end
      dllp(2'b01, 12'd10);
      checks++; if (bus.seq_err !== 1'b1 || bus.purge_valid !== 1'b0 || bus.ackd_seq !== 12'd0)
         begin failures++; $display("FAIL err_far got=%0b/%0b/%0d exp=1/0/0", bus.seq_err, bus.purge_valid, bus.ackd_seq); end
      dllp(2'b01, 12'd5);
      checks++; if (bus.seq_err !== 1'b1 || bus.purge_valid !== 1'b0)
         begin failures++; $display("FAIL err_edge_out got=%0b/%0b exp=1/0", bus.seq_err, bus.purge_valid); end
      dllp(2'b01, 12'd4);
      checks++; if (bus.seq_err !== 1'b0 || bus.purge_count !== 12'd4 || bus.ackd_seq !== 12'd4)
         begin failures++; $display("FAIL err_edge_in got=%0b/%0d/%0d exp=0/4/4", bus.seq_err, bus.purge_count, bus.ackd_seq); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      send(5);
      dllp(2'b10, 12'd1);
      checks++; if (bus.rep_start !== 1'b1) begin failures++; $display("FAIL b2b_first_start got=%0b exp=1", bus.rep_start); end
      step();
      bus.rep_done = 1'b1;
      dllp(2'b10, 12'd1);
      bus.rep_done = 1'b0;
      checks++; if (bus.rep_start !== 1'b1 || bus.rep_count !== 12'd3 || bus.purge_valid !== 1'b0)
         begin failures++; $display("FAIL b2b_second_start got=%0b/%0d/%0b exp=1/3/0", bus.rep_start, bus.rep_count, bus.purge_valid); end
      step();
      dllp(2'b01, 12'd2);
      checks++; if (bus.purge_count !== 12'd1 || bus.ackd_seq !== 12'd2 || bus.rep_busy !== 1'b1)
         begin failures++; $display("FAIL b2b_ack_in_replay got=%0d/%0d/%0b exp=1/2/1", bus.purge_count, bus.ackd_seq, bus.rep_busy); end
      rst = 1'b1; step(); rst = 1'b0;
      checks++; if (bus.rep_busy !== 1'b0 || bus.tx_ready !== 1'b1 || bus.next_seq !== 12'd0 || bus.ackd_seq !== 12'hFFF || bus.rep_count !== 12'd0)
         begin failures++; $display("FAIL b2b_reset got=%0b/%0b/%0d/%0h/%0d exp=0/1/0/fff/0", bus.rep_busy, bus.tx_ready, bus.next_seq, bus.ackd_seq, bus.rep_count); end
      bus.rep_done = 1'b1; step(); bus.rep_done = 1'b0;
      checks++; if (bus.rep_busy !== 1'b0 || bus.rep_start !== 1'b0 || bus.tx_ready !== 1'b1)
         begin failures++; $display("FAIL b2b_done_ignored got=%0b/%0b/%0b exp=0/0/1", bus.rep_busy, bus.rep_start, bus.tx_ready); end
   endtask

   initial begin
      test_reset();
      test_ack();
      test_nak();
      test_timeout();
      test_wrap();
      test_seq_err();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
